// File: rtl/multicycle_control_if.sv
// Purpose: bundles the multi-cycle controller's sequencing inputs and datapath
//          enables into one interface.
// Ports:
//   start_i, Op_i, mem_ready_i        : run level, opcode, memory handshake (into the controller)
//   ALUOp_o .. IRWrite_o               : datapath enables (out of the controller)
//   busy_o, illegal_o, timeout_o       : status and sticky error flags
//   retired_o                          : retired-instruction counter
// Modports: master = the controller, slave = the surrounding CPU / environment.
interface multicycle_control_if #(
  parameter int unsigned ALUOP_W = 2,
  parameter int unsigned CNT_W   = 16
);
  logic               start_i;
  logic [6:0]         Op_i;
  logic               mem_ready_i;
  logic [ALUOP_W-1:0] ALUOp_o;
  logic               ALUSrc_o;
  logic               RegWrite_o;
  logic               MemRead_o;
  logic               MemWrite_o;
  logic               MemtoReg_o;
  logic               Branch_o;
  logic               PCWrite_o;
  logic               IRWrite_o;
  logic               busy_o;
  logic               illegal_o;
  logic               timeout_o;
  logic [CNT_W-1:0]   retired_o;

  modport master (
    input  start_i, Op_i, mem_ready_i,
    output ALUOp_o, ALUSrc_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o,
           Branch_o, PCWrite_o, IRWrite_o, busy_o, illegal_o, timeout_o, retired_o
  );

  modport slave (
    output start_i, Op_i, mem_ready_i,
    input  ALUOp_o, ALUSrc_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o,
           Branch_o, PCWrite_o, IRWrite_o, busy_o, illegal_o, timeout_o, retired_o
  );
endinterface

// File: rtl/multicycle_control.sv
// Purpose: multi-cycle CPU controller. Walks each instruction through
//          FETCH/DECODE/EXEC/MEM/WB, drives the datapath enables per state,
//          waits on a variable-latency memory and traps illegal opcodes and
//          memory timeouts into a sticky ERROR state.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-low reset
//   bus   : multicycle_control_if.master (run control, opcode, memory ready,
//           datapath enables, status flags, retired counter)
module multicycle_control #(
  parameter int unsigned ALUOP_W = 2,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TO_W    = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  multicycle_control_if.master bus
);

  localparam logic [6:0]   OP_R      = 7'b0110011;
  localparam logic [6:0]   OP_I      = 7'b0010011;
  localparam logic [6:0]   OP_LOAD   = 7'b0000011;
  localparam logic [6:0]   OP_STORE  = 7'b0100011;
  localparam logic [6:0]   OP_BRANCH = 7'b1100011;
  localparam logic [TO_W:0] TO_LIM   = (TO_W+1)'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_R       = 3'd0,
    C_I       = 3'd1,
    C_LOAD    = 3'd2,
    C_STORE   = 3'd3,
    C_BRANCH  = 3'd4,
    C_ILLEGAL = 3'd5
  } op_class_t;

  state_t            state_q, state_d;
  op_class_t         cls_q, cls_d, cls_dec;
  logic [TO_W-1:0]   wait_q, wait_d;
  logic [TO_W:0]     wait_inc;
  logic              wait_expired;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              retire;

  logic [1:0] alu_op;
  logic       alu_src, reg_write, mem_read, mem_write, mem_to_reg;
  logic       branch, pc_write, ir_write;

  // Opcode to class; anything unlisted is illegal.
  function automatic op_class_t classify(input logic [6:0] op);
    case (op)
      OP_R:      return C_R;
      OP_I:      return C_I;
      OP_LOAD:   return C_LOAD;
      OP_STORE:  return C_STORE;
      OP_BRANCH: return C_BRANCH;
      default:   return C_ILLEGAL;
    endcase
  endfunction

  // ALU operation class for the latched instruction class.
  function automatic logic [1:0] alu_op_of(input op_class_t c);
    case (c)
      C_I:             return 2'b10;
      C_LOAD, C_STORE: return 2'b01;
      C_BRANCH:        return 2'b11;
      default:         return 2'b00;
    endcase
  endfunction

  // Immediate operand for I-type and address generation.
  function automatic logic alu_src_of(input op_class_t c);
    return (c == C_I) || (c == C_LOAD) || (c == C_STORE);
  endfunction

  // State and bookkeeping registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      cls_q     <= C_R;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      retired_q <= retired_d;
    end
  end

  // Next-state, bookkeeping and enable decode.
  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    wait_d     = '0;  // any cycle that is not a failed wait clears the counter
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    retired_d  = retired_q;
    retire     = 1'b0;
    alu_op     = 2'b00;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    branch     = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    cls_dec    = classify(bus.Op_i);
    wait_inc   = {1'b0, wait_q} + (TO_W+1)'(1);
    // This failed wait would be the TIMEOUT-th in a row.
    wait_expired = (wait_inc == TO_LIM);

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) state_d = S_FETCH;
      end

      S_FETCH: begin
        mem_read = 1'b1;
        if (bus.mem_ready_i) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_expired) begin
          state_d   = S_ERROR;
          timeout_d = 1'b1;
        end else begin
          wait_d = TO_W'(wait_inc);
        end
      end

      S_DECODE: begin
        if (cls_dec == C_ILLEGAL) begin
          state_d   = S_ERROR;
          illegal_d = 1'b1;
        end else begin
          cls_d   = cls_dec;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        alu_op  = alu_op_of(cls_q);
        alu_src = alu_src_of(cls_q);
        case (cls_q)
          C_BRANCH: begin
            branch   = 1'b1;
            pc_write = 1'b1;
            retire   = 1'b1;
          end
          C_LOAD, C_STORE: state_d = S_MEM;
          default:         state_d = S_WB;
        endcase
      end

      S_MEM: begin
        alu_op    = alu_op_of(cls_q);
        alu_src   = alu_src_of(cls_q);
        mem_read  = (cls_q == C_LOAD);
        mem_write = (cls_q == C_STORE);
        if (bus.mem_ready_i) begin
          if (cls_q == C_STORE) begin
            pc_write = 1'b1;
            retire   = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_expired) begin
          state_d   = S_ERROR;
          timeout_d = 1'b1;
        end else begin
          wait_d = TO_W'(wait_inc);
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        mem_to_reg = (cls_q == C_LOAD);
        retire     = 1'b1;
      end

      S_ERROR: begin
        state_d = S_ERROR;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Instruction boundary: count it, then continue or park depending on start_i.
    if (retire) begin
      retired_d = retired_q + CNT_W'(1);
      state_d   = bus.start_i ? S_FETCH : S_IDLE;
    end
  end

  assign bus.ALUOp_o    = ALUOP_W'(alu_op);
  assign bus.ALUSrc_o   = alu_src;
  assign bus.RegWrite_o = reg_write;
  assign bus.MemRead_o  = mem_read;
  assign bus.MemWrite_o = mem_write;
  assign bus.MemtoReg_o = mem_to_reg;
  assign bus.Branch_o   = branch;
  assign bus.PCWrite_o  = pc_write;
  assign bus.IRWrite_o  = ir_write;
  assign bus.busy_o     = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign bus.illegal_o  = illegal_q;
  assign bus.timeout_o  = timeout_q;
  assign bus.retired_o  = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Purpose: self-checking bench for multicycle_control. Each scenario is turned
//          into a per-cycle trace (stimulus + expected outputs) by an
//          instruction-level model, then replayed and compared every cycle.
module tb_multicycle_control;

  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned TO_W    = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned EXP_W   = ALUOP_W + 11 + CNT_W;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_XX = 7'b1111111;

  logic clk = 1'b0;
  logic rst_i;

  multicycle_control_if #(.ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) bus ();

  multicycle_control #(
    .ALUOP_W(ALUOP_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W), .CNT_W(CNT_W)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               rst_n;
    bit               start;
    logic [6:0]       op;
    bit               ready;
    logic [EXP_W-1:0] exp;
  } rec_t;

  rec_t trace[$];

  // Architectural model state
  logic [CNT_W-1:0] m_ret;
  bit               m_ill, m_tmo;

  int checks = 0;
  int errors = 0;
  int n_regw, n_pcw, n_memw, n_memr, n_m2r;

  function automatic logic [6:0] rnd_op();
    return 7'($urandom);
  endfunction

  function automatic bit rnd_bit();
    return 1'($urandom);
  endfunction

  // 0 R, 1 I, 2 LOAD, 3 STORE, 4 BRANCH, 5 illegal
  function automatic int class_of(input logic [6:0] op);
    case (op)
      OP_R:    return 0;
      OP_I:    return 1;
      OP_LD:   return 2;
      OP_ST:   return 3;
      OP_BR:   return 4;
      default: return 5;
    endcase
  endfunction

  function automatic logic [1:0] aop_of(input int c);
    case (c)
      1:       return 2'b10;
      2, 3:    return 2'b01;
      4:       return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic push(input bit rst_n, input bit st, input logic [6:0] op, input bit rdy,
                      input logic [1:0] aop, input bit asrc, input bit regw, input bit memr,
                      input bit memw, input bit m2r, input bit br, input bit pcw,
                      input bit irw, input bit busy);
    rec_t r;
    r.rst_n = rst_n;
    r.start = st;
    r.op    = op;
    r.ready = rdy;
    r.exp   = {ALUOP_W'(aop), asrc, regw, memr, memw, m2r, br, pcw, irw, busy,
               m_ill, m_tmo, m_ret};
    trace.push_back(r);
  endtask

  // Cycles with no enables (IDLE or ERROR); ready is irrelevant there.
  task automatic quiet(input int n, input bit st);
    for (int i = 0; i < n; i++)
      push(1, st, rnd_op(), rnd_bit(), 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_cycles(input int n);
    m_ret = '0;
    m_ill = 0;
    m_tmo = 0;
    for (int i = 0; i < n; i++)
      push(0, 0, rnd_op(), rnd_bit(), 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One instruction: fwait/mwait = ready-low cycles before ready in FETCH/MEM,
  // start_i is low from instruction cycle drop_at on, abort_mem >= 0 pulls
  // reset after that many MEM wait cycles.
  task automatic gen_instr(input logic [6:0] op, input int fwait, input int mwait,
                           input int drop_at, input int abort_mem);
    int k;
    int c;
    logic [1:0] aop;
    bit asrc, ld, sto;
    k    = 0;
    c    = class_of(op);
    aop  = aop_of(c);
    asrc = (c == 1) || (c == 2) || (c == 3);
    ld   = (c == 2);
    sto  = (c == 3);
    for (int i = 0; i < fwait && i < int'(TIMEOUT); i++) begin
      push(1, k < drop_at, rnd_op(), 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 1);
      k++;
    end
    if (fwait >= int'(TIMEOUT)) begin
      m_tmo = 1;
      return;
    end
    push(1, k < drop_at, rnd_op(), 1, 2'b00, 0, 0, 1, 0, 0, 0, 0, 1, 1);
    k++;
    push(1, k < drop_at, op, rnd_bit(), 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    k++;
    if (c == 5) begin
      m_ill = 1;
      return;
    end
    push(1, k < drop_at, rnd_op(), rnd_bit(), aop, asrc, 0, 0, 0, 0, c == 4, c == 4, 0, 1);
    k++;
    if (c == 4) begin
      m_ret++;
      return;
    end
    if (ld || sto) begin
      for (int i = 0; i < mwait && i < int'(TIMEOUT); i++) begin
        if (i == abort_mem) begin
          reset_cycles(1);
          return;
        end
        push(1, k < drop_at, rnd_op(), 0, aop, asrc, 0, ld, sto, 0, 0, 0, 0, 1);
        k++;
      end
      if (mwait >= int'(TIMEOUT)) begin
        m_tmo = 1;
        return;
      end
      push(1, k < drop_at, rnd_op(), 1, aop, asrc, 0, ld, sto, 0, 0, sto, 0, 1);
      k++;
      if (sto) begin
        m_ret++;
        return;
      end
    end
    push(1, k < drop_at, rnd_op(), rnd_bit(), 2'b00, 0, 1, 0, 0, ld, 0, 1, 0, 1);
    m_ret++;
  endtask

  // Replay the trace: drive just after the rising edge, compare on the falling edge.
  task automatic run_trace(input string tag);
    logic [EXP_W-1:0] act;
    for (int i = 0; i < trace.size(); i++) begin
      @(posedge clk);
      #1;
      rst_i           = trace[i].rst_n;
      bus.start_i     = trace[i].start;
      bus.Op_i        = trace[i].op;
      bus.mem_ready_i = trace[i].ready;
      @(negedge clk);
      act = {bus.ALUOp_o, bus.ALUSrc_o, bus.RegWrite_o, bus.MemRead_o, bus.MemWrite_o,
             bus.MemtoReg_o, bus.Branch_o, bus.PCWrite_o, bus.IRWrite_o, bus.busy_o,
             bus.illegal_o, bus.timeout_o, bus.retired_o};
      checks++;
      if (act !== trace[i].exp) begin
        errors++;
        $display("FAIL %s cycle %0d: outputs %h, required %h", tag, i, act, trace[i].exp);
      end
      n_regw += int'(bus.RegWrite_o);
      n_pcw  += int'(bus.PCWrite_o);
      n_memw += int'(bus.MemWrite_o);
      n_memr += int'(bus.MemRead_o);
      n_m2r  += int'(bus.MemtoReg_o);
    end
    trace.delete();
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic clear_counts();
    n_regw = 0; n_pcw = 0; n_memw = 0; n_memr = 0; n_m2r = 0;
  endtask

  initial begin
    rst_i           = 1'b0;
    bus.start_i     = 1'b0;
    bus.Op_i        = '0;
    bus.mem_ready_i = 1'b0;
    m_ret = '0; m_ill = 0; m_tmo = 0;

    // R then I, ready immediately
    clear_counts();
    reset_cycles(2);
    quiet(1, 1);
    gen_instr(OP_R, 0, 0, 1000, -1);
    gen_instr(OP_I, 0, 0, 0, -1);
    quiet(2, 0);
    run_trace("r_then_i");
    chk("r_i_retired", int'(bus.retired_o), 2);
    chk("r_i_regwrite_pulses", n_regw, 2);

    // LOAD with three MEM wait cycles
    clear_counts();
    reset_cycles(1);
    quiet(1, 1);
    gen_instr(OP_LD, 0, 3, 1, -1);
    quiet(1, 0);
    run_trace("load_wait3");
    chk("load_memread_cycles", n_memr, 5);
    chk("load_memtoreg_pulses", n_m2r, 1);
    chk("load_retired", int'(bus.retired_o), 1);

    // STORE then BRANCH back to back
    clear_counts();
    reset_cycles(1);
    quiet(1, 1);
    gen_instr(OP_ST, 0, 0, 1000, -1);
    gen_instr(OP_BR, 0, 0, 0, -1);
    quiet(1, 0);
    run_trace("store_branch");
    chk("sb_pcwrite_pulses", n_pcw, 2);
    chk("sb_regwrite_pulses", n_regw, 0);
    chk("sb_memwrite_pulses", n_memw, 1);
    chk("sb_retired", int'(bus.retired_o), 2);

    // Illegal opcode, ERROR held until reset
    clear_counts();
    reset_cycles(1);
    quiet(1, 1);
    gen_instr(OP_XX, 0, 0, 1000, -1);
    quiet(3, 1);
    run_trace("illegal");
    chk("illegal_flag", int'(bus.illegal_o), 1);
    chk("illegal_busy", int'(bus.busy_o), 0);
    reset_cycles(1);
    quiet(1, 0);
    run_trace("illegal_reset");
    chk("illegal_cleared", int'(bus.illegal_o), 0);

    // FETCH timeout, then ready on the last allowed cycle, then MEM timeout
    reset_cycles(1);
    quiet(1, 1);
    gen_instr(OP_R, 15, 0, 1000, -1);
    quiet(2, 1);
    run_trace("fetch_timeout");
    chk("fetch_timeout_flag", int'(bus.timeout_o), 1);
    reset_cycles(1);
    quiet(1, 1);
    gen_instr(OP_R, 14, 0, 1000, -1);
    gen_instr(OP_ST, 0, 15, 0, -1);
    quiet(2, 1);
    run_trace("ready_15th_then_mem_timeout");
    chk("mem_timeout_flag", int'(bus.timeout_o), 1);
    chk("ready_15th_retired", int'(bus.retired_o), 1);

    // Drop start in EXEC, then reset in the middle of a MEM wait
    clear_counts();
    reset_cycles(1);
    quiet(1, 1);
    gen_instr(OP_R, 1, 0, 3, -1);
    quiet(2, 0);
    quiet(1, 1);
    gen_instr(OP_LD, 0, 10, 1000, 2);
    quiet(1, 0);
    run_trace("drop_start_and_reset");
    chk("abort_retired", int'(bus.retired_o), 0);
    chk("drop_regwrite_pulses", n_regw, 1);

    // Retired counter wraps after 2^CNT_W branches
    clear_counts();
    reset_cycles(1);
    quiet(1, 1);
    for (int n = 0; n < (1 << CNT_W); n++)
      gen_instr(OP_BR, n % 3, 0, (n == (1 << CNT_W) - 1) ? 0 : 1000, -1);
    quiet(1, 0);
    run_trace("retire_wrap");
    chk("wrap_retired", int'(bus.retired_o), 0);
    chk("wrap_pcwrite_pulses", n_pcw, 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
